// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin share of one DRAM request port among NUM_REQ
// requesters, with single outstanding-read tracking and response routing.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   req_valid/ready     per-requester handshake (ready one-hot or zero)
//   req_is_write        per-requester packet type (1 = write)
//   req_address/payload flattened per-requester packet fields
//   resp_valid/data     one-cycle read response to the owning requester
//   mem_req_*           packet toward DRAM, held until mem_req_ready
//   mem_source          index of the granted requester
//   mem_resp_*          DRAM read response (always accepted)
//   err_timeout         sticky: read response never arrived
//   err_unexpected      sticky: stray or mis-sourced response
module mem_bus_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int SRC_W        = 3,
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_is_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_payload,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_is_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_payload,
  output logic [SRC_W-1:0]          mem_source,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_resp_data,
  input  logic [SRC_W-1:0]          mem_resp_source,
  output logic                      err_timeout,
  output logic                      err_unexpected
);

  localparam int NSLOT = 2**SRC_W;
  localparam int CNT_W = $clog2(RESP_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [SRC_W:0]   NREQ_X   = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_REQ = SRC_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_t;

  state_t state, state_nxt;

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] winner;
  logic [SRC_W-1:0] rr_nxt;
  logic [SRC_W-1:0] off;
  logic [SRC_W:0]   sum;
  logic             found;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [CNT_W-1:0] cnt;

  logic take;
  logic deliver;
  logic to_hit;
  logic unexp;

  // Unpacked per-slot views padded to 2^SRC_W so a SRC_W-bit index is exact.
  logic [ADDR_W-1:0] addr_arr [NSLOT];
  logic [DATA_W-1:0] data_arr [NSLOT];
  logic [NSLOT-1:0]  wr_ext;

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NUM_REQ) begin : g_use
      assign addr_arr[g] = req_address[g*ADDR_W +: ADDR_W];
      assign data_arr[g] = req_payload[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign addr_arr[g] = '0;
      assign data_arr[g] = '0;
    end
  end

  assign wr_ext = NSLOT'(req_is_write);

  // Rotate valids so bit 0 is rr_ptr, take the first set bit, rotate back.
  always_comb begin
    dbl   = {req_valid, req_valid} >> rr_ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = SRC_W'(k);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= NREQ_X) begin
      sum = sum - NREQ_X;
    end
    winner = sum[SRC_W-1:0];
    rr_nxt = (winner == LAST_REQ) ? '0 : winner + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    deliver   = 1'b0;
    to_hit    = 1'b0;
    unexp     = 1'b0;
    unique case (state)
      IDLE: begin
        unexp = mem_resp_valid;
        if (found) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        unexp = mem_resp_valid;
        if (mem_req_ready) begin
          state_nxt = mem_is_write ? IDLE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid) begin
          deliver   = 1'b1;
          unexp     = (mem_resp_source != mem_source);
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset_n so the grant strobe drops at once under reset.
  assign req_ready = (take && reset_n)
                   ? (NUM_REQ'(1) << winner) : '0;
  assign mem_req_valid = (state == ISSUE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr         <= '0;
      cnt            <= '0;
      mem_is_write   <= 1'b0;
      mem_address    <= '0;
      mem_payload    <= '0;
      mem_source     <= '0;
      resp_valid     <= '0;
      resp_data      <= '0;
      err_timeout    <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (take) begin
        mem_is_write <= wr_ext[winner];
        mem_address  <= addr_arr[winner];
        mem_payload  <= data_arr[winner];
        mem_source   <= winner;
        rr_ptr       <= rr_nxt;
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT_RESP) begin
        cnt <= cnt + 1'b1;
      end
      // A mis-sourced response still goes to the requester that issued it.
      if (deliver) begin
        resp_valid <= NUM_REQ'(1) << mem_source;
        resp_data  <= mem_resp_data;
      end
      if (unexp) begin
        err_unexpected <= 1'b1;
      end
      if (to_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter.
// Stimulus queues expected grants/packets/responses; a monitor pops them.
module tb_mem_bus_arbiter;

  localparam int NR = 4;
  localparam int SW = 3;
  localparam int AW = 64;
  localparam int DW = 64;

  typedef struct {
    logic          w;
    logic [63:0]   a;
    logic [63:0]   d;
    logic [SW-1:0] s;
  } pkt_t;

  typedef struct {
    int          idx;
    logic [63:0] d;
  } resp_t;

  logic             clk;
  logic             reset_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_is_write;
  logic [NR*AW-1:0] req_address;
  logic [NR*DW-1:0] req_payload;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_data;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_is_write;
  logic [AW-1:0]    mem_address;
  logic [DW-1:0]    mem_payload;
  logic [SW-1:0]    mem_source;
  logic             mem_resp_valid;
  logic [DW-1:0]    mem_resp_data;
  logic [SW-1:0]    mem_resp_source;
  logic             err_timeout;
  logic             err_unexpected;

  mem_bus_arbiter #(
    .NUM_REQ(NR),
    .SRC_W(SW),
    .ADDR_W(AW),
    .DATA_W(DW),
    .RESP_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_is_write(req_is_write),
    .req_address(req_address),
    .req_payload(req_payload),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_is_write(mem_is_write),
    .mem_address(mem_address),
    .mem_payload(mem_payload),
    .mem_source(mem_source),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .mem_resp_source(mem_resp_source),
    .err_timeout(err_timeout),
    .err_unexpected(err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int    grant_q[$];
  pkt_t  pkt_q[$];
  resp_t resp_q[$];

  int grant_cyc;
  int hs_cyc;
  int resp_cyc;
  int grant_cnt;
  int t0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input logic w,
                         input logic [63:0] a, input logic [63:0] d);
    req_is_write[i] = w;
    req_address[i*AW +: AW] = a;
    req_payload[i*DW +: DW] = d;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_mem_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_wr"}, mem_is_write, 0);
    chk({tag, "_mem_addr"}, mem_address, 0);
    chk({tag, "_mem_pay"}, mem_payload, 0);
    chk({tag, "_mem_src"}, mem_source, 0);
    chk({tag, "_err_to"}, err_timeout, 0);
    chk({tag, "_err_ux"}, err_unexpected, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_zero("rst");
    step(2);
    reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  int   e;
  pkt_t p;
  resp_t r;
  always @(negedge clk) begin
    if (reset_n) begin
      if (req_ready != 0) begin
        grant_cyc = cyc;
        grant_cnt++;
        if (grant_q.size() == 0) begin
          chk("unexp_grant", req_ready, 0);
        end else begin
          e = grant_q.pop_front();
          chk("grant", req_ready, 64'(1) << e);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        hs_cyc = cyc;
        if (pkt_q.size() == 0) begin
          chk("unexp_pkt", mem_address, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          p = pkt_q.pop_front();
          chk("pkt_wr", mem_is_write, p.w);
          chk("pkt_addr", mem_address, p.a);
          chk("pkt_pay", mem_payload, p.d);
          chk("pkt_src", mem_source, p.s);
        end
      end
      if (resp_valid != 0) begin
        resp_cyc = cyc;
        if (resp_q.size() == 0) begin
          chk("unexp_resp", resp_valid, 0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_vld", resp_valid, 64'(1) << r.idx);
          chk("resp_data", resp_data, r.d);
        end
      end
    end
  end

  initial begin
    reset_n         = 1'b0;
    req_valid       = '0;
    req_is_write    = '0;
    req_address     = '0;
    req_payload     = '0;
    mem_req_ready   = 1'b0;
    mem_resp_valid  = 1'b0;
    mem_resp_data   = '0;
    mem_resp_source = '0;
    grant_cyc = -100;
    hs_cyc    = -100;
    resp_cyc  = -100;
    grant_cnt = 0;
    step(1);
    check_zero("init");
    step(1);
    reset_n = 1'b1;
    step(1);

    // Single read from req0, DRAM replies 3 cycles after issue.
    set_req(0, 1'b0, 64'h100, 64'h0);
    mem_req_ready = 1'b1;
    grant_q.push_back(0);
    pkt_q.push_back('{1'b0, 64'h100, 64'h0, 3'd0});
    resp_q.push_back('{0, 64'h1122334455667788});
    t0 = cyc;
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    step(3);
    mem_resp_valid  = 1'b1;
    mem_resp_source = 3'd0;
    mem_resp_data   = 64'h1122334455667788;
    step(1);
    mem_resp_valid = 1'b0;
    step(1);
    chk("rd_grant_t", 64'(grant_cyc - t0), 0);
    chk("rd_issue_t", 64'(hs_cyc - t0), 1);
    chk("rd_resp_t", 64'(resp_cyc - t0), 5);

    // Round-robin over four held writes.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      set_req(i, 1'b1, 64'h1000 + 64'(i*16), 64'hA0 + 64'(i));
    end
    for (int i = 0; i < 5; i++) begin
      grant_q.push_back(i % NR);
      pkt_q.push_back('{1'b1, 64'h1000 + 64'((i % NR)*16),
                        64'hA0 + 64'(i % NR), 3'(i % NR)});
    end
    grant_cnt = 0;
    t0 = cyc;
    req_valid = 4'hF;
    step(9);
    req_valid = '0;
    step(2);
    chk("rr_count", 64'(grant_cnt), 5);
    chk("rr_last_t", 64'(grant_cyc - t0), 8);
    chk("rr_pkt_left", 64'(pkt_q.size()), 0);

    // Backpressure on req1 write while req2 waits.
    set_req(1, 1'b1, 64'h2000, 64'h5555AAAA5555AAAA);
    set_req(2, 1'b1, 64'h3000, 64'h33);
    grant_q.push_back(1);
    pkt_q.push_back('{1'b1, 64'h2000, 64'h5555AAAA5555AAAA, 3'd1});
    grant_q.push_back(2);
    pkt_q.push_back('{1'b1, 64'h3000, 64'h33, 3'd2});
    mem_req_ready = 1'b0;
    t0 = cyc;
    req_valid = 4'b0010;
    step(1);
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", mem_req_valid, 1);
      chk("bp_addr", mem_address, 64'h2000);
      chk("bp_pay", mem_payload, 64'h5555AAAA5555AAAA);
      chk("bp_ready", req_ready, 0);
      step(1);
    end
    mem_req_ready = 1'b1;
    step(2);
    req_valid = '0;
    step(2);
    chk("bp_grant2_t", 64'(grant_cyc - t0), 7);

    // Read timeout from req3, then a late response.
    set_req(3, 1'b0, 64'h4000, 64'h0);
    grant_q.push_back(3);
    pkt_q.push_back('{1'b0, 64'h4000, 64'h0, 3'd3});
    t0 = cyc;
    req_valid = 4'b1000;
    step(1);
    req_valid = '0;
    step(16);
    chk("to_before", err_timeout, 0);
    step(1);
    chk("to_set", err_timeout, 1);
    chk("to_hs_t", 64'(hs_cyc - t0), 1);
    chk("to_no_ux", err_unexpected, 0);
    mem_resp_valid  = 1'b1;
    mem_resp_source = 3'd3;
    mem_resp_data   = 64'hBAD;
    step(1);
    mem_resp_valid = 1'b0;
    chk("late_ux", err_unexpected, 1);
    chk("late_no_resp", resp_valid, 0);
    step(1);
    chk("late_no_resp2", resp_valid, 0);

    // Wrong source on a read from req2.
    do_reset();
    set_req(2, 1'b0, 64'h5000, 64'h0);
    grant_q.push_back(2);
    pkt_q.push_back('{1'b0, 64'h5000, 64'h0, 3'd2});
    resp_q.push_back('{2, 64'hCAFEF00D12345678});
    t0 = cyc;
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    step(1);
    mem_resp_valid  = 1'b1;
    mem_resp_source = 3'd1;
    mem_resp_data   = 64'hCAFEF00D12345678;
    step(1);
    mem_resp_valid = 1'b0;
    chk("ws_ux", err_unexpected, 1);
    step(1);
    chk("ws_resp_t", 64'(resp_cyc - t0), 3);

    // Reset during WAIT_RESP of a req1 read.
    set_req(1, 1'b0, 64'h6000, 64'h0);
    grant_q.push_back(1);
    pkt_q.push_back('{1'b0, 64'h6000, 64'h0, 3'd1});
    req_valid = 4'b0010;
    step(1);
    req_valid = '0;
    step(2);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("mid");
    step(2);
    reset_n = 1'b1;
    set_req(1, 1'b1, 64'h7000, 64'h71);
    set_req(3, 1'b1, 64'h8000, 64'h83);
    grant_q.push_back(1);
    pkt_q.push_back('{1'b1, 64'h7000, 64'h71, 3'd1});
    grant_q.push_back(3);
    pkt_q.push_back('{1'b1, 64'h8000, 64'h83, 3'd3});
    t0 = cyc;
    req_valid = 4'b1010;
    step(1);
    req_valid = 4'b1000;
    step(2);
    req_valid = '0;
    step(2);
    chk("mr_grant3_t", 64'(grant_cyc - t0), 2);

    chk("end_grant_q", 64'(grant_q.size()), 0);
    chk("end_pkt_q", 64'(pkt_q.size()), 0);
    chk("end_resp_q", 64'(resp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single DRAM request port among NUM_REQ requesters (cores, caches, DMA) using round-robin arbitration.
- Captures the winner's bus packet, drives it onto the memory side and holds it until accepted.
- Tracks the one outstanding read and routes the read payload back to the originating requester.
- Writes are posted; the memory model services one packet at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SRC_W, 3, width of the source ID; must satisfy 2^SRC_W >= NUM_REQ
- ADDR_W, 64, address width
- DATA_W, 64, bus_packet_payload_t width
- RESP_TIMEOUT, 1024, cycles to wait for a read response before flagging an error

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept strobe (one-hot or zero)
- req_is_write  in  NUM_REQ  1 = bus_write_data, 0 = bus_read_data
- req_address  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses slice i
- req_payload  in  NUM_REQ*DATA_W  flattened write payloads
- resp_valid  out  NUM_REQ  one-cycle read-response pulse to the owning requester
- resp_data  out  DATA_W  read payload, shared by all requesters and qualified by resp_valid
- mem_req_valid  out  1  packet valid toward DRAM
- mem_req_ready  in  1  DRAM accepts the packet
- mem_is_write  out  1  packet type
- mem_address  out  ADDR_W  packet address
- mem_payload  out  DATA_W  packet payload
- mem_source  out  SRC_W  index of the granted requester
- mem_resp_valid  in  1  DRAM read response valid; always accepted
- mem_resp_data  in  DATA_W  DRAM read payload
- mem_resp_source  in  SRC_W  source echoed by DRAM
- err_timeout  out  1  sticky; a read response did not arrive within RESP_TIMEOUT
- err_unexpected  out  1  sticky; response arrived with no read outstanding, or with the wrong source

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: all outputs 0, resp_data 0, both error flags 0.
  - Internal state: state=IDLE, rr_ptr=0, timeout counter 0.
  - Any outstanding read is abandoned.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - Winner = first requester with req_valid=1, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; that cycle is the handshake.
  - The packet is captured on that clock edge: mem_source=winner, rr_ptr=(winner+1) mod NUM_REQ, next state ISSUE.
  - No req_valid set: req_ready=0 and the block stays in IDLE.
- ISSUE:
  - mem_req_valid=1 with the captured fields held stable until mem_req_ready=1.
  - Handshake with a write: return to IDLE.
  - Handshake with a read: go to WAIT_RESP and clear the timeout counter.
  - req_ready=0 throughout.
- WAIT_RESP:
  - req_ready=0 and mem_req_valid=0; the counter increments each cycle.
  - mem_resp_valid=1 with source equal to mem_source: on the next cycle resp_valid[source]=1 for exactly one cycle, resp_data=mem_resp_data, state IDLE.
  - Source mismatch: set err_unexpected, still deliver to the captured mem_source, go to IDLE.
  - Counter reaching RESP_TIMEOUT-1 without a response: set err_timeout, go to IDLE, no resp_valid pulse.
- Response in IDLE or ISSUE (e.g. a late response after a timeout): dropped, err_unexpected=1.
- Minimum read latency: request accept T, mem_req_valid T+1, response at T+1+k arrives at the requester at T+2+k.
- A write occupies the bus for 2 cycles when mem_req_ready is tied high.
- A requester that drops req_valid before being granted loses nothing; fairness is guaranteed only while valid is held.
- Simultaneous mem_req_ready and mem_resp_valid cannot legally occur; mem_resp_valid in ISSUE is treated as unexpected.
- Reset asserted mid-operation: immediate return to IDLE with all outputs cleared.

Test Plan:
- Single read: req0 read addr 0x100, DRAM replies 0x1122334455667788 after 3 cycles -> req_ready[0] at T, mem_req_valid T+1, resp_valid[0] at T+5 with that data.
- Round-robin: all 4 requesters hold writes, mem_req_ready=1 -> grant order 0,1,2,3,0; one accept every 2 cycles; mem_source matches each grant.
- Backpressure: mem_req_ready low for 5 cycles during ISSUE -> mem_address/mem_payload stable, no req_ready pulse until the handshake completes.
- Timeout: RESP_TIMEOUT=16, no response -> err_timeout=1 after 16 WAIT_RESP cycles, state IDLE. A late response then sets err_unexpected and produces no resp_valid.
- Wrong source: read granted to req2, response carries source 1 -> err_unexpected=1, resp_valid[2] pulses.
- Reset mid-read: reset_n low during WAIT_RESP -> all outputs 0 asynchronously; after release, req3 is granted first only if req0..2 are idle (rr_ptr=0).
